// File: rtl/canny_pkg.sv
// Shared types and width helpers for the Canny front-end blocks.
package canny_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACTIVE,
        GAP,
        FLUSH,
        DONE
    } state_t;

    // Bits needed to index 0..n-1.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to count 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth register pipeline with asynchronous active-low reset.
module sig_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] q_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) q_reg <= '0;
                    else        q_reg <= din;
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) q_reg <= '0;
                    else        q_reg <= g_stage[gi-1].q_reg;
                end
            end
        end
    endgenerate

    assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/matrix_window_ctrl.sv
// Frame sequencer in front of the 3x3 generator: forwards pixels, injects a padding
// line after the last row, and emits window-centre coordinates aligned with the matrix.
module matrix_window_ctrl
    import canny_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    IMG_WIDTH  = 640,
    parameter int                    IMG_HEIGHT = 480,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0,
    parameter int                    FLUSH_GAP  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_vsync,
    input  logic                         in_href,
    input  logic                         in_clken,
    input  logic [DATA_WIDTH-1:0]        in_y,
    output logic                         out_vsync,
    output logic                         out_href,
    output logic                         out_clken,
    output logic [DATA_WIDTH-1:0]        out_y,
    output logic                         win_valid,
    output logic                         win_edge,
    output logic [idx_w(IMG_HEIGHT)-1:0] cen_row,
    output logic [idx_w(IMG_WIDTH)-1:0]  cen_col,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         err_ovf
);

    localparam int CW = cnt_w(IMG_WIDTH);
    localparam int RW = cnt_w(IMG_HEIGHT);
    localparam int XW = idx_w(IMG_WIDTH);
    localparam int YW = idx_w(IMG_HEIGHT);
    localparam int GW = cnt_w(FLUSH_GAP);

    state_t                state_reg, state_next;
    logic [CW-1:0]         col_reg, col_next;
    logic [RW-1:0]         row_reg, row_next, row_inc;
    logic [GW-1:0]         gap_reg, gap_next;
    logic [XW-1:0]         fcnt_reg, fcnt_next;
    logic                  vsync_d_reg, href_d_reg;
    logic                  err_reg, err_next;
    logic                  ovs_reg, ovs_next, ohref_reg, ohref_next, oclk_reg, oclk_next;
    logic [DATA_WIDTH-1:0] oy_reg, oy_next;
    logic [RW-1:0]         pix_row_reg, pix_row_next;
    logic [XW-1:0]         pix_col_reg, pix_col_next;
    logic                  done_reg;
    logic                  vs_rise, vs_fall, href_fall, last_line, ovf_pix;

    assign vs_rise   = in_vsync & ~vsync_d_reg;
    assign vs_fall   = ~in_vsync & vsync_d_reg;
    assign href_fall = ~in_href & href_d_reg;
    assign row_inc   = row_reg + RW'(1);
    assign last_line = href_fall && (row_inc == RW'(IMG_HEIGHT));
    assign ovf_pix   = in_clken && (col_reg == CW'(IMG_WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (vs_rise) state_next = ACTIVE;
            ACTIVE:  if (last_line || vs_fall) state_next = GAP;
            GAP:     if (gap_reg == GW'(FLUSH_GAP - 1)) state_next = FLUSH;
            FLUSH:   if (fcnt_reg == XW'(IMG_WIDTH - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        col_next     = col_reg;
        row_next     = row_reg;
        gap_next     = gap_reg;
        fcnt_next    = fcnt_reg;
        err_next     = err_reg;
        ovs_next     = 1'b0;
        ohref_next   = 1'b0;
        oclk_next    = 1'b0;
        oy_next      = '0;
        pix_row_next = '0;
        pix_col_next = '0;
        case (state_reg)
            IDLE: begin
                if (vs_rise) begin
                    col_next  = '0;
                    row_next  = '0;
                    gap_next  = '0;
                    fcnt_next = '0;
                    err_next  = 1'b0;
                end
            end
            ACTIVE: begin
                ovs_next     = in_vsync;
                ohref_next   = in_href;
                oclk_next    = in_clken & ~ovf_pix;
                oy_next      = in_y;
                pix_row_next = row_reg;
                pix_col_next = col_reg[XW-1:0];
                if (ovf_pix) err_next = 1'b1;
                if (in_clken && in_href && col_reg != CW'(IMG_WIDTH)) col_next = col_reg + CW'(1);
                if (href_fall) begin
                    row_next = row_inc;
                    col_next = '0;
                end
                // A vsync drop that coincides with the final line ending is a complete frame.
                if (vs_fall && !last_line) err_next = 1'b1;
            end
            GAP: begin
                ovs_next = 1'b1;
                gap_next = gap_reg + GW'(1);
                if (in_href) err_next = 1'b1;
            end
            FLUSH: begin
                ovs_next     = 1'b1;
                ohref_next   = 1'b1;
                oclk_next    = 1'b1;
                oy_next      = PAD_VALUE;
                pix_row_next = RW'(IMG_HEIGHT);
                pix_col_next = fcnt_reg;
                fcnt_next    = fcnt_reg + XW'(1);
                if (in_href) err_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg     <= '0;
            row_reg     <= '0;
            gap_reg     <= '0;
            fcnt_reg    <= '0;
            vsync_d_reg <= 1'b0;
            href_d_reg  <= 1'b0;
            err_reg     <= 1'b0;
            ovs_reg     <= 1'b0;
            ohref_reg   <= 1'b0;
            oclk_reg    <= 1'b0;
            oy_reg      <= '0;
            pix_row_reg <= '0;
            pix_col_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            col_reg     <= col_next;
            row_reg     <= row_next;
            gap_reg     <= gap_next;
            fcnt_reg    <= fcnt_next;
            vsync_d_reg <= in_vsync;
            href_d_reg  <= in_href;
            err_reg     <= err_next;
            ovs_reg     <= ovs_next;
            ohref_reg   <= ohref_next;
            oclk_reg    <= oclk_next;
            oy_reg      <= oy_next;
            pix_row_reg <= pix_row_next;
            pix_col_reg <= pix_col_next;
            done_reg    <= (state_reg == DONE);
        end
    end

    // The window centred one row up and one column left of the pixel now entering the generator.
    logic          pre_valid, pre_edge;
    logic [YW-1:0] pre_row;
    logic [XW-1:0] pre_col;

    always_comb begin
        pre_valid = oclk_reg && (pix_row_reg != '0) && (pix_col_reg != '0);
        pre_row   = '0;
        pre_col   = '0;
        pre_edge  = 1'b0;
        if (pre_valid) begin
            pre_row  = YW'(pix_row_reg - RW'(1));
            pre_col  = pix_col_reg - XW'(1);
            pre_edge = (pre_row == '0) || (pre_row == YW'(IMG_HEIGHT - 1)) ||
                       (pre_col == '0) || (pre_col == XW'(IMG_WIDTH - 2));
        end
    end

    logic [YW+XW+1:0] win_bus;

    sig_delay #(
        .WIDTH (YW + XW + 2),
        .DEPTH (2)
    ) u_win_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({pre_valid, pre_edge, pre_row, pre_col}),
        .dout  (win_bus)
    );

    assign {win_valid, win_edge, cen_row, cen_col} = win_bus;

    assign out_vsync  = ovs_reg;
    assign out_href   = ohref_reg;
    assign out_clken  = oclk_reg;
    assign out_y      = oy_reg;
    assign busy       = (state_reg != IDLE);
    assign frame_done = done_reg;
    assign err_ovf    = err_reg;

endmodule
